atm_transaction: RTL and testbench
==================================

Name: atm_transaction

Overview:
- Transaction controller directly downstream of cardhandling.
- Consumes the account balance and wrong_psw that cardhandling produces.
- Tracks PIN attempts and executes deposit, withdraw and inquiry operations.
- Returns updated_balance and op_done to cardhandling for write-back.

Parameters:
- balance_width, 20: width of balance, amount and updated_balance.
- max_tries, 3: wrong-PIN attempts that lock the session.
- tries_width, 2: width of the attempt counter; must satisfy 2^tries_width > max_tries.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- card_in  input  1  card present; same signal that drives cardhandling.
- psw_valid  input  1  one-cycle strobe: keypad has submitted a PIN; wrong_psw is valid this cycle.
- wrong_psw  input  1  from cardhandling: 1 = PIN mismatch.
- balance  input  balance_width  from cardhandling: current account balance.
- op_start  input  1  one-cycle request to execute op_sel with amount.
- op_sel  input  2  00 none, 01 deposit, 10 withdraw, 11 inquiry.
- amount  input  balance_width  transaction amount, unsigned.
- updated_balance  output  balance_width  new balance to cardhandling.
- op_done  output  1  one-cycle pulse: updated_balance is valid for write-back.
- authorized  output  1  PIN accepted; session in READY, EXEC or DONE.
- card_locked  output  1  max_tries wrong PINs entered.
- insufficient  output  1  last withdraw exceeded balance.
- overflow  output  1  last deposit exceeded 2^balance_width-1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, fail_cnt=0, latched op/amount=0.
  - All outputs 0.
- States: IDLE, AUTH, READY, EXEC, DONE, LOCKED.
- Card removal: card_in=0 in any state forces IDLE on the next edge.
  - Clears fail_cnt, insufficient, overflow and card_locked.
  - If removal occurs in EXEC, op_done is never issued.
- IDLE: card_in=1 -> AUTH.
- AUTH:
  - psw_valid=1 and wrong_psw=0 -> READY; fail_cnt cleared.
  - psw_valid=1 and wrong_psw=1 -> fail_cnt+1. If the new count equals max_tries -> LOCKED, otherwise stay in AUTH.
  - psw_valid=0 -> hold; wrong_psw is ignored.
- LOCKED: card_locked=1; stays until card_in=0. psw_valid and op_start are ignored.
- READY:
  - op_start=1 with op_sel!=00 -> latch op_sel and amount, clear insufficient and overflow, go to EXEC.
  - op_start with op_sel=00 is ignored.
  - psw_valid is ignored.
- EXEC (one cycle), using balance sampled this cycle:
  - Deposit: compute sum as balance+amount at balance_width+1 bits.
    - If the carry bit is 1: overflow=1, updated_balance=balance.
    - Else: updated_balance=sum[balance_width-1:0].
  - Withdraw:
    - If amount>balance: insufficient=1, updated_balance=balance.
    - Else: updated_balance=balance-amount. amount==balance is legal and gives 0.
  - Inquiry: updated_balance=balance.
  - Next state: DONE.
- DONE: op_done=1 for exactly this cycle, then READY.
- Latency: op_start sampled at edge N -> EXEC during cycle N..N+1 -> op_done high between edges N+1 and N+2.
- op_start arriving during EXEC or DONE is dropped; no queueing.
- Output hold rules:
  - updated_balance holds its value until the next EXEC, or is cleared by card removal or reset.
  - Error flags hold until the next accepted op_start, card removal or reset.
- authorized=1 in READY, EXEC and DONE only.
- A failed operation (overflow or insufficient) still pulses op_done, with updated_balance = unchanged balance. Write-back is therefore harmless.

Test Plan:
- Reset: rst=0 mid-DONE with op_done=1 -> op_done, authorized and updated_balance all 0 immediately (asynchronous), state IDLE.
- PIN retry/lock, max_tries=3:
  - card_in=1, then two psw_valid pulses with wrong_psw=1 -> still AUTH, card_locked=0.
  - Third wrong pulse -> card_locked=1 on next edge.
  - op_start with op_sel=10 -> no op_done.
  - card_in=0 -> card_locked=0, IDLE.
- Good PIN after one wrong: wrong then correct -> authorized=1. Then card out/in -> fail_cnt restarts at 0; three more wrong PINs are needed to lock.
- Withdraw:
  - balance=500, amount=200, op_sel=10 -> op_done pulse exactly 2 edges after op_start, updated_balance=300.
  - amount=500 -> updated_balance=0, insufficient=0.
  - amount=501 -> insufficient=1, updated_balance=500, op_done still pulses.
- Deposit overflow, balance_width=20:
  - balance=1048000, amount=575 -> updated_balance=1048575, overflow=0.
  - amount=576 -> overflow=1, updated_balance=1048000.
- Abort: op_start (deposit 100) then card_in=0 during EXEC -> no op_done, IDLE, all flags 0. Also check that op_start with op_sel=00 in READY produces no EXEC.

Source files
------------

// File: rtl/atm_transaction.sv
// atm_transaction: PIN-attempt tracking and deposit/withdraw/inquiry execution downstream of cardhandling
module atm_transaction #(
    parameter int balance_width = 20,
    parameter int max_tries     = 3,
    parameter int tries_width   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     card_in,
    input  logic                     psw_valid,
    input  logic                     wrong_psw,
    input  logic [balance_width-1:0] balance,
    input  logic                     op_start,
    input  logic [1:0]               op_sel,
    input  logic [balance_width-1:0] amount,
    output logic [balance_width-1:0] updated_balance,
    output logic                     op_done,
    output logic                     authorized,
    output logic                     card_locked,
    output logic                     insufficient,
    output logic                     overflow
);
    typedef enum logic [2:0] {IDLE, AUTH, READY, EXEC, DONE, LOCKED} state_t;
    state_t                   state, state_nx;
    logic [tries_width-1:0]   fail_cnt, fail_nx;
    logic [1:0]               op_q;
    logic [balance_width-1:0] amt_q;
    logic [balance_width:0]   sum;
    logic                     accept;
    assign accept      = card_in && state == READY && op_start && op_sel != 2'b00;
    assign sum         = {1'b0, balance} + {1'b0, amt_q};
    assign op_done     = state == DONE;
    assign authorized  = state == READY || state == EXEC || state == DONE;
    assign card_locked = state == LOCKED;
    // session state and wrong-PIN counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fail_cnt <= '0;
        end else begin
            state    <= state_nx;
            fail_cnt <= fail_nx;
        end
    end
    // next state; card removal overrides everything, including an in-flight EXEC
    always_comb begin
        state_nx = state;
        fail_nx  = fail_cnt;
        if (!card_in) begin
            state_nx = IDLE;
            fail_nx  = '0;
        end else begin
            case (state)
                IDLE:  state_nx = AUTH;
                AUTH:  if (psw_valid) begin
                           if (!wrong_psw) begin
                               state_nx = READY;
                               fail_nx  = '0;
                           end else begin
                               fail_nx  = fail_cnt + 1'b1;
                               state_nx = fail_nx == tries_width'(max_tries) ? LOCKED : AUTH;
                           end
                       end
                READY: state_nx = accept ? EXEC : READY;
                EXEC:  state_nx = DONE;
                DONE:  state_nx = READY;
                LOCKED: state_nx = LOCKED;
                default: state_nx = IDLE;
            endcase
        end
    end
    // latch the request, then compute the result in EXEC against the balance presented that cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q            <= '0;
            amt_q           <= '0;
            updated_balance <= '0;
            insufficient    <= 1'b0;
            overflow        <= 1'b0;
        end else if (!card_in) begin
            op_q            <= '0;
            amt_q           <= '0;
            updated_balance <= '0;
            insufficient    <= 1'b0;
            overflow        <= 1'b0;
        end else if (accept) begin
            op_q         <= op_sel;
            amt_q        <= amount;
            insufficient <= 1'b0;
            overflow     <= 1'b0;
        end else if (state == EXEC) begin
            updated_balance <= (op_q == 2'b01 && !sum[balance_width]) ? sum[balance_width-1:0] :
                               (op_q == 2'b10 && amt_q <= balance)    ? balance - amt_q :
                                                                        balance;
            overflow        <= op_q == 2'b01 && sum[balance_width];
            insufficient    <= op_q == 2'b10 && amt_q > balance;
        end
    end
endmodule

// File: tb/tb_atm_transaction.sv
// tb_atm_transaction: scenario tasks plus randomized operations checked against an arithmetic model
module tb_atm_transaction;
    localparam int BW = 20;
    localparam longint MAXV = (64'd1 << BW) - 1;
    logic          clk = 1'b0;
    logic          rst, card_in, psw_valid, wrong_psw, op_start;
    logic [1:0]    op_sel;
    logic [BW-1:0] balance, amount, updated_balance;
    logic          op_done, authorized, card_locked, insufficient, overflow;
    int            pass_cnt = 0;
    int            total_cnt = 0;

    atm_transaction #(.balance_width(BW), .max_tries(3), .tries_width(2)) dut (
        .clk(clk), .rst(rst), .card_in(card_in), .psw_valid(psw_valid), .wrong_psw(wrong_psw),
        .balance(balance), .op_start(op_start), .op_sel(op_sel), .amount(amount),
        .updated_balance(updated_balance), .op_done(op_done), .authorized(authorized),
        .card_locked(card_locked), .insufficient(insufficient), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [1:0] sel, input logic [BW-1:0] bal, amt,
                                  output logic [BW-1:0] ub, output logic ins, ovf);
        longint b = longint'(bal);
        longint a = longint'(amt);
        ins = 1'b0;
        ovf = 1'b0;
        ub  = bal;
        if (sel == 2'd1) begin
            if (b + a > MAXV) ovf = 1'b1;
            else ub = BW'(b + a);
        end else if (sel == 2'd2) begin
            if (a > b) ins = 1'b1;
            else ub = BW'(b - a);
        end
    endfunction

    task automatic pin(input logic wrong);
        psw_valid = 1'b1;
        wrong_psw = wrong;
        tick();
        psw_valid = 1'b0;
        wrong_psw = 1'b0;
    endtask

    task automatic enter_session();
        card_in = 1'b0;
        tick();
        card_in = 1'b1;
        tick();
        pin(1'b0);
        total_cnt++;
        if (authorized !== 1'b1) $display("FAIL session_auth: authorized=%b expected 1", authorized);
        else pass_cnt++;
    endtask

    task automatic run_op(input logic [1:0] sel, input logic [BW-1:0] bal, amt, exp_ub,
                          input logic exp_ins, exp_ovf, input string name);
        balance  = bal;
        amount   = amt;
        op_sel   = sel;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        total_cnt++;
        if (op_done !== 1'b0) $display("FAIL %s_early: op_done=%b expected 0 in EXEC", name, op_done);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (op_done !== 1'b1 || updated_balance !== exp_ub || insufficient !== exp_ins || overflow !== exp_ovf)
            $display("FAIL %s: op_done=%b ub=%0d ins=%b ovf=%b expected op_done=1 ub=%0d ins=%b ovf=%b",
                     name, op_done, updated_balance, insufficient, overflow, exp_ub, exp_ins, exp_ovf);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (op_done !== 1'b0 || authorized !== 1'b1)
            $display("FAIL %s_after: op_done=%b authorized=%b expected 0 1", name, op_done, authorized);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b0; card_in = 1'b1; psw_valid = 1'b0; wrong_psw = 1'b0;
        op_start = 1'b0; op_sel = 2'b00; balance = '0; amount = '0;
        repeat (2) tick();
        total_cnt++;
        if ({updated_balance, op_done, authorized, card_locked, insufficient, overflow} !== '0)
            $display("FAIL reset_outputs: ub=%0d done=%b auth=%b lock=%b ins=%b ovf=%b expected all 0",
                     updated_balance, op_done, authorized, card_locked, insufficient, overflow);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        pin(1'b0);
        balance = 20'd500; amount = 20'd100; op_sel = 2'b01; op_start = 1'b1;
        tick();
        op_start = 1'b0;
        tick();
        total_cnt++;
        if (op_done !== 1'b1 || updated_balance !== 20'd600)
            $display("FAIL reset_pre_done: op_done=%b ub=%0d expected 1 600", op_done, updated_balance);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (op_done !== 1'b0 || authorized !== 1'b0 || updated_balance !== '0)
            $display("FAIL reset_async: op_done=%b auth=%b ub=%0d expected 0 0 0", op_done, authorized, updated_balance);
        else pass_cnt++;
        tick();
        rst = 1'b1;
        tick();
        total_cnt++;
        if (authorized !== 1'b0 || op_done !== 1'b0)
            $display("FAIL reset_idle: auth=%b op_done=%b expected 0 0", authorized, op_done);
        else pass_cnt++;
    endtask

    task automatic test_lock();
        card_in = 1'b0;
        tick();
        card_in = 1'b1;
        tick();
        pin(1'b1);
        pin(1'b1);
        total_cnt++;
        if (card_locked !== 1'b0 || authorized !== 1'b0)
            $display("FAIL lock_two_wrong: lock=%b auth=%b expected 0 0", card_locked, authorized);
        else pass_cnt++;
        wrong_psw = 1'b1;
        tick();
        total_cnt++;
        if (card_locked !== 1'b0)
            $display("FAIL lock_strobe_ignored: lock=%b expected 0", card_locked);
        else pass_cnt++;
        pin(1'b1);
        total_cnt++;
        if (card_locked !== 1'b1) $display("FAIL lock_third: lock=%b expected 1", card_locked);
        else pass_cnt++;
        pin(1'b0);
        balance = 20'd500; amount = 20'd10; op_sel = 2'b10; op_start = 1'b1;
        tick();
        op_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (op_done !== 1'b0 || authorized !== 1'b0 || card_locked !== 1'b1)
                $display("FAIL lock_ignores_op%0d: done=%b auth=%b lock=%b expected 0 0 1", i, op_done, authorized, card_locked);
            else pass_cnt++;
            tick();
        end
        card_in = 1'b0;
        tick();
        total_cnt++;
        if (card_locked !== 1'b0) $display("FAIL lock_removed: lock=%b expected 0", card_locked);
        else pass_cnt++;
    endtask

    task automatic test_good_after_wrong();
        card_in = 1'b1;
        tick();
        pin(1'b1);
        pin(1'b0);
        total_cnt++;
        if (authorized !== 1'b1 || card_locked !== 1'b0)
            $display("FAIL retry_good: auth=%b lock=%b expected 1 0", authorized, card_locked);
        else pass_cnt++;
        card_in = 1'b0; tick(); card_in = 1'b1; tick();
        pin(1'b1);
        card_in = 1'b0; tick(); card_in = 1'b1; tick();
        pin(1'b1);
        pin(1'b1);
        total_cnt++;
        if (card_locked !== 1'b0)
            $display("FAIL retry_count_restart: lock=%b expected 0", card_locked);
        else pass_cnt++;
        pin(1'b1);
        total_cnt++;
        if (card_locked !== 1'b1) $display("FAIL retry_relock: lock=%b expected 1", card_locked);
        else pass_cnt++;
    endtask

    task automatic test_withdraw();
        enter_session();
        run_op(2'b10, 20'd500, 20'd200, 20'd300, 1'b0, 1'b0, "wd_200");
        run_op(2'b10, 20'd500, 20'd500, 20'd0, 1'b0, 1'b0, "wd_equal");
        run_op(2'b10, 20'd500, 20'd501, 20'd500, 1'b1, 1'b0, "wd_insuff");
        op_sel = 2'b00; op_start = 1'b1;
        tick();
        op_start = 1'b0;
        repeat (2) tick();
        total_cnt++;
        if (op_done !== 1'b0 || insufficient !== 1'b1 || updated_balance !== 20'd500 || authorized !== 1'b1)
            $display("FAIL nop_ignored: done=%b ins=%b ub=%0d auth=%b expected 0 1 500 1",
                     op_done, insufficient, updated_balance, authorized);
        else pass_cnt++;
    endtask

    task automatic test_deposit();
        enter_session();
        run_op(2'b01, 20'd1048000, 20'd575, 20'd1048575, 1'b0, 1'b0, "dep_max");
        run_op(2'b01, 20'd1048000, 20'd576, 20'd1048000, 1'b0, 1'b1, "dep_ovf");
        run_op(2'b11, 20'd7, 20'd99, 20'd7, 1'b0, 1'b0, "inquiry");
    endtask

    task automatic test_abort();
        enter_session();
        balance = 20'd10; amount = 20'd100; op_sel = 2'b01; op_start = 1'b1;
        tick();
        op_start = 1'b0;
        card_in = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if ({updated_balance, op_done, authorized, card_locked, insufficient, overflow} !== '0)
                $display("FAIL abort%0d: ub=%0d done=%b auth=%b lock=%b ins=%b ovf=%b expected all 0",
                         i, updated_balance, op_done, authorized, card_locked, insufficient, overflow);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        enter_session();
        balance = 20'd1000; amount = 20'd1; op_sel = 2'b10; op_start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 2) op_start = 1'b0;
            if (op_done === 1'b1) dones++;
        end
        total_cnt++;
        if (dones != 1 || updated_balance !== 20'd999)
            $display("FAIL back_to_back: done_pulses=%0d ub=%0d expected 1 999", dones, updated_balance);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [1:0]    sel;
        logic [BW-1:0] bal, amt, ub;
        logic          ins, ovf;
        enter_session();
        for (int i = 0; i < 40; i++) begin
            sel = 2'($urandom_range(1, 3));
            bal = BW'($urandom);
            case ($urandom_range(0, 3))
                0: amt = BW'($urandom);
                1: amt = bal;
                2: amt = BW'(MAXV - longint'(bal));
                default: amt = BW'(MAXV - longint'(bal) + 1);
            endcase
            model(sel, bal, amt, ub, ins, ovf);
            run_op(sel, bal, amt, ub, ins, ovf, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_good_after_wrong();
        test_withdraw();
        test_deposit();
        test_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
